count_run_sequencer: RTL



---
 rtl/count_run_sequencer_pkg.sv | 26 ++
 rtl/count_run_sequencer_if.sv | 28 ++
 rtl/count_run_sequencer_rr_arbiter.sv | 36 +++
 rtl/count_run_sequencer.sv | 111 +++++++++++
 4 files changed

// File: rtl/count_run_sequencer_pkg.sv
// rtl/count_run_sequencer_pkg.sv - shared types and helpers for the count-run sequencer
package count_seq_pkg;

    localparam int CW_DEFAULT = 4;
    localparam int MAX_REQ    = 8;
    localparam int IDX_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/count_run_sequencer_if.sv
// rtl/count_run_sequencer_if.sv - requester and counter-pin bundle of the count-run sequencer
interface count_run_sequencer_if
    import count_seq_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CW    = CW_DEFAULT
) ();

    logic [N_REQ-1:0]    req;
    logic [N_REQ*CW-1:0] req_target;
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    done;
    logic                busy;
    logic                ctr_reset;
    logic                ctr_enable;
    logic [CW-1:0]       ctr_count;

    modport master (
        output req, req_target, ctr_count,
        input  grant, done, busy, ctr_reset, ctr_enable
    );

    modport slave (
        input  req, req_target, ctr_count,
        output grant, done, busy, ctr_reset, ctr_enable
    );

endinterface

// File: rtl/count_run_sequencer_rr_arbiter.sv
// rtl/count_run_sequencer_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter
    import count_seq_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    logic found;

    // First pass covers ptr..N_REQ-1, second pass wraps to 0..ptr-1.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[k] && (k >= int'(ptr))) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = IDX_W'(k);
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[k] && (k < int'(ptr))) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/count_run_sequencer.sv
// rtl/count_run_sequencer.sv - round-robin owner of a shared up-counter, runs it to each requester's target
module count_run_sequencer
    import count_seq_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CW    = CW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    count_run_sequencer_if.slave bus
);

    seq_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             ctr_reset_q, ctr_reset_d;
    logic [CW-1:0]    target_q, target_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [N_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W-1:0] ptr_after_owner;
    logic             owner_active;
    logic             at_target;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (bus.req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // ptr holds the highest-priority index, so the last owner goes to the back of the line.
    assign ptr_after_owner = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign owner_active    = |(bus.req & grant_q);
    assign at_target       = (bus.ctr_count == target_q);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        ctr_reset_d = 1'b0;
        target_d    = target_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d     = CLEAR;
                    grant_d     = arb_grant;
                    owner_d     = arb_idx;
                    ctr_reset_d = 1'b1;
                    for (int k = 0; k < N_REQ; k++) begin
                        if (arb_grant[k]) begin
                            target_d = bus.req_target[k*CW +: CW];
                        end
                    end
                end
            end
            CLEAR, RUN: begin
                if (!owner_active) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_after_owner;
                end else if (state_q == CLEAR) begin
                    state_d = RUN;
                end else if (at_target) begin
                    state_d = DONE;
                    done_d  = grant_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = ptr_after_owner;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            ctr_reset_q <= 1'b0;
            target_q    <= '0;
            ptr_q       <= '0;
            owner_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            ctr_reset_q <= ctr_reset_d;
            target_q    <= target_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.ctr_reset  = ctr_reset_q;
    // Combinational so the counter freezes on the exact edge it hits the target or the owner drops.
    assign bus.ctr_enable = (state_q == RUN) && owner_active && !at_target;

endmodule
